// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and RV32I opcode constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        WAIT_INSTR = 3'd1,
        EXECUTE    = 3'd2,
        LOAD       = 3'd3,
        WAIT_DATA  = 3'd4,
        STORE      = 3'd5,
        WAIT_STORE = 3'd6,
        HALT       = 3'd7
    } cpuState_t;

    // addi x0,x0,0 -- harmless instruction held in instr after reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // States in which the memory port carries the load/store address
    function automatic logic isDataPhase(input cpuState_t s);
        return (s == LOAD) || (s == WAIT_DATA) || (s == STORE) || (s == WAIT_STORE);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch, execute, optional load/store, halt.
// Memory strobes and rf_we are decoded from the current state and are forced
// low while reset is high so reset silences the bus immediately.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    output logic [3:0]  mem_wmask,
    input  logic        mem_wbusy,
    output logic [31:0] instr,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic        isSYSTEM,
    input  logic        isBranch,
    input  logic [4:0]  rdId,
    input  logic [31:0] next_pc,
    input  logic [31:0] ls_addr,
    input  logic [3:0]  store_wmask,
    output logic [31:0] pc,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        halted
);

    cpuState_t curState, nxtState;

    assign state    = curState;
    assign halted   = (curState == HALT);
    assign mem_addr = isDataPhase(curState) ? ls_addr : pc;

    // State, program counter and instruction register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= FETCH;
            pc       <= RESET_PC;
            instr    <= NOP_INSTR;
        end else begin
            curState <= nxtState;
            if (curState == WAIT_INSTR && !mem_rbusy)
                instr <= mem_rdata;
            // wrap-around is already in next_pc; only word-align it
            if (curState == EXECUTE)
                pc <= {next_pc[31:2], 2'b00};
        end
    end

    // Next-state decode and per-state memory/write-back strobes
    always_comb begin
        nxtState  = curState;
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0000;
        rf_we     = 1'b0;
        case (curState)
            FETCH: begin
                mem_rstrb = 1'b1;
                nxtState  = WAIT_INSTR;
            end
            WAIT_INSTR: begin
                if (!mem_rbusy) nxtState = EXECUTE;
            end
            EXECUTE: begin
                rf_we = !(isLoad | isStore | isBranch | isSYSTEM) && (rdId != 5'd0);
                if (isLoad)        nxtState = LOAD;
                else if (isStore)  nxtState = STORE;
                else if (isSYSTEM) nxtState = HALT;
                else               nxtState = FETCH;
            end
            LOAD: begin
                mem_rstrb = 1'b1;
                nxtState  = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (!mem_rbusy) begin
                    rf_we    = (rdId != 5'd0);
                    nxtState = FETCH;
                end
            end
            STORE: begin
                mem_wmask = store_wmask;
                nxtState  = WAIT_STORE;
            end
            WAIT_STORE: begin
                if (!mem_wbusy) nxtState = FETCH;
            end
            HALT: begin
                nxtState = HALT;
            end
            default: nxtState = FETCH;
        endcase
        if (reset) begin
            mem_rstrb = 1'b0;
            mem_wmask = 4'b0000;
            rf_we     = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. The bench plays memory and decoder;
// a per-instruction transaction model predicts the bus activity cycle by cycle.
module tb_cpu_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_rdata, instr, next_pc, ls_addr, pc;
    logic        mem_rstrb, mem_rbusy, mem_wbusy, rf_we, halted;
    logic [3:0]  mem_wmask, store_wmask;
    logic        isLoad, isStore, isSYSTEM, isBranch;
    logic [4:0]  rdId;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    logic [31:0] modelPc;

    cpu_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wmask(mem_wmask),
        .mem_wbusy(mem_wbusy), .instr(instr), .isLoad(isLoad), .isStore(isStore),
        .isSYSTEM(isSYSTEM), .isBranch(isBranch), .rdId(rdId), .next_pc(next_pc),
        .ls_addr(ls_addr), .store_wmask(store_wmask), .pc(pc), .rf_we(rf_we),
        .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Full observable bus/debug picture for one cycle
    task automatic chkCyc(input string tag, input int st, input logic rs, input logic [3:0] wm,
                          input logic we, input logic [31:0] a);
        chk({tag, ".state"},  32'(state),     32'(st));
        chk({tag, ".rstrb"},  32'(mem_rstrb), 32'(rs));
        chk({tag, ".wmask"},  32'(mem_wmask), 32'(wm));
        chk({tag, ".rf_we"},  32'(rf_we),     32'(we));
        chk({tag, ".addr"},   mem_addr,       a);
        chk({tag, ".pc"},     pc,             modelPc);
        chk({tag, ".halted"}, 32'(halted),    32'(st == 7));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random decoder/datapath values for cycles where the sequencer must ignore them
    task automatic garbage();
        isLoad = 1'($urandom); isStore = 1'($urandom); isSYSTEM = 1'($urandom);
        isBranch = 1'($urandom); rdId = 5'($urandom); next_pc = $urandom;
        ls_addr = $urandom; store_wmask = 4'($urandom); mem_wbusy = 1'($urandom);
    endtask

    task automatic resetChecks(input string tag);
        chk({tag, ".state"}, 32'(state),     32'd0);
        chk({tag, ".pc"},    pc,             RST_PC);
        chk({tag, ".instr"}, instr,          32'h0000_0013);
        chk({tag, ".rf_we"}, 32'(rf_we),     32'd0);
        chk({tag, ".rstrb"}, 32'(mem_rstrb), 32'd0);
        chk({tag, ".wmask"}, 32'(mem_wmask), 32'd0);
        chk({tag, ".halt"},  32'(halted),    32'd0);
    endtask

    // Asynchronous reset pulse mid-cycle; returns just after release
    task automatic pulseReset(input string tag);
        #2 reset = 1'b1;
        mem_rbusy = 1'b0; mem_wbusy = 1'b0;
        #1 resetChecks({tag, ".async"});
        step();
        resetChecks({tag, ".held"});
        reset   = 1'b0;
        modelPc = RST_PC;
    endtask

    // kind: 0 ALU, 1 branch, 2 load, 3 store, 4 system (halt)
    // ib/db: busy cycles for instruction / data phase; abortWait resets inside WAIT_DATA
    task automatic doInstr(input int kind, input int ib, input int db, input logic [4:0] rd,
                           input logic [31:0] npc, input logic [31:0] lsa, input logic [3:0] wm,
                           input logic [31:0] word, input bit abortWait);
        garbage(); mem_rbusy = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk); chkCyc("fetch", 0, 1'b1, 4'd0, 1'b0, modelPc);
        step();
        for (int i = 0; i < ib; i++) begin
            garbage(); mem_rbusy = 1'b1; mem_rdata = $urandom;
            @(negedge clk); chkCyc("wInstrBusy", 1, 1'b0, 4'd0, 1'b0, modelPc);
            step();
        end
        garbage(); mem_rbusy = 1'b0; mem_rdata = word;
        @(negedge clk); chkCyc("wInstr", 1, 1'b0, 4'd0, 1'b0, modelPc);
        step();
        isLoad = (kind == 2); isStore = (kind == 3); isBranch = (kind == 1);
        isSYSTEM = (kind == 4); rdId = rd; next_pc = npc; ls_addr = lsa; store_wmask = wm;
        mem_rbusy = 1'($urandom); mem_rdata = $urandom; mem_wbusy = 1'($urandom);
        @(negedge clk);
        chk("exec.instr", instr, word);
        chkCyc("exec", 2, 1'b0, 4'd0, (kind == 0) && (rd != 5'd0), modelPc);
        step();
        modelPc = npc & ~32'h3;
        next_pc = $urandom;
        if (kind == 2) begin
            mem_rbusy = 1'($urandom);
            @(negedge clk); chkCyc("load", 3, 1'b1, 4'd0, 1'b0, lsa);
            step();
            for (int i = 0; i < db; i++) begin
                mem_rbusy = 1'b1; mem_wbusy = 1'($urandom); next_pc = $urandom;
                @(negedge clk); chkCyc("wDataBusy", 4, 1'b0, 4'd0, 1'b0, lsa);
                if (abortWait) begin
                    pulseReset("rstWait");
                    return;
                end
                step();
            end
            mem_rbusy = 1'b0;
            @(negedge clk); chkCyc("wData", 4, 1'b0, 4'd0, rd != 5'd0, lsa);
            step();
        end else if (kind == 3) begin
            mem_wbusy = 1'($urandom); mem_rbusy = 1'($urandom);
            @(negedge clk); chkCyc("store", 5, 1'b0, wm, 1'b0, lsa);
            step();
            for (int i = 0; i < db; i++) begin
                mem_wbusy = 1'b1; mem_rbusy = 1'($urandom);
                @(negedge clk); chkCyc("wStoreBusy", 6, 1'b0, 4'd0, 1'b0, lsa);
                step();
            end
            mem_wbusy = 1'b0;
            @(negedge clk); chkCyc("wStore", 6, 1'b0, 4'd0, 1'b0, lsa);
            step();
        end else if (kind == 4) begin
            for (int i = 0; i < 20; i++) begin
                mem_rbusy = 1'($urandom); mem_wbusy = 1'($urandom);
                next_pc = $urandom; rdId = 5'($urandom);
                @(negedge clk); chkCyc("halt", 7, 1'b0, 4'd0, 1'b0, modelPc);
                step();
            end
        end
    endtask

    initial begin
        reset = 1'b1; mem_rbusy = 1'b0; mem_rdata = '0;
        garbage();
        modelPc = RST_PC;
        repeat (3) step();
        @(negedge clk); resetChecks("reset");
        step();
        reset = 1'b0;

        // addi x1,x0,5 with zero-wait memory
        doInstr(0, 0, 0, 5'd1, 32'h4, $urandom, 4'd0, 32'h00500093, 1'b0);
        // instruction fetch stalled 3 cycles
        doInstr(0, 3, 0, 5'd3, 32'h8, $urandom, 4'd0, $urandom, 1'b0);
        // load from 0x100 into x2, data busy 2 cycles
        doInstr(2, 0, 2, 5'd2, 32'hC, 32'h100, 4'd0, $urandom, 1'b0);
        // half-word store, write busy 1 cycle
        doInstr(3, 0, 1, 5'd0, 32'h10, 32'h204, 4'b0011, $urandom, 1'b0);
        // branch and rd=0 ALU op never write back; load into x0 neither
        doInstr(1, 1, 0, 5'd7, 32'h40, $urandom, 4'd0, $urandom, 1'b0);
        doInstr(0, 0, 0, 5'd0, 32'h44, $urandom, 4'd0, $urandom, 1'b0);
        doInstr(2, 0, 0, 5'd0, 32'h48, 32'h80, 4'd0, $urandom, 1'b0);
        // misaligned next_pc gets aligned; top of address space then wrap to 0
        doInstr(0, 0, 0, 5'd4, 32'hFFFF_FFFF, $urandom, 4'd0, $urandom, 1'b0);
        doInstr(0, 0, 0, 5'd4, 32'h0000_0000, $urandom, 4'd0, $urandom, 1'b0);

        for (int n = 0; n < 40; n++) begin
            doInstr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    5'($urandom), $urandom, $urandom, 4'($urandom), $urandom, 1'b0);
        end

        // reset while a load waits for data
        doInstr(2, 0, 2, 5'd5, 32'h300, 32'h100, 4'd0, $urandom, 1'b1);
        doInstr(0, 0, 0, 5'd6, 32'h4, $urandom, 4'd0, $urandom, 1'b0);

        // ebreak halts until reset
        doInstr(4, 0, 0, 5'd0, 32'h500, $urandom, 4'd0, 32'h00100073, 1'b0);
        pulseReset("rstHalt");
        doInstr(0, 1, 0, 5'd9, 32'h8, $urandom, 4'd0, $urandom, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_addr  output  32  memory byte address.
REQ-005 SHALL have port mem_rstrb  output  1  one-cycle read request.
REQ-006 SHALL have port mem_rdata  input  32  read data, valid when mem_rbusy low after a request.
REQ-007 SHALL have port mem_rbusy  input  1  read in progress.
REQ-008 SHALL have port mem_wmask  output  4  byte write enables, one-cycle write request.
REQ-009 SHALL have port mem_wbusy  input  1  write in progress.
REQ-010 SHALL have port instr  output  32  instruction register, feeds the decoder.
REQ-011 SHALL have ports isLoad, isStore, isSYSTEM, isBranch  input  1 each  decoded flags for instr.
REQ-012 SHALL have port rdId  input  5  decoded destination register.
REQ-013 SHALL have ports next_pc, ls_addr  input  32 each  datapath-computed next PC and load/store address.
REQ-014 SHALL have port store_wmask  input  4  datapath-computed store byte mask.
REQ-015 SHALL have port pc  output  32  program counter.
REQ-016 SHALL have port rf_we  output  1  register-file write-back strobe.
REQ-017 SHALL have ports state  output  3 and halted  output  1  debug visibility.

Function
REQ-018 SHALL implement states FETCH=0, WAIT_INSTR=1, EXECUTE=2, LOAD=3, WAIT_DATA=4, STORE=5, WAIT_STORE=6, HALT=7.
REQ-019 FETCH: SHALL assert mem_rstrb with mem_addr=pc for exactly one cycle, then go to WAIT_INSTR.
REQ-020 WAIT_INSTR: while mem_rbusy=1 SHALL hold; on the first cycle with mem_rbusy=0, SHALL latch instr<=mem_rdata and go to EXECUTE.
REQ-021 EXECUTE: SHALL load pc<=next_pc with bits [1:0] forced to 0; next state LOAD if isLoad, STORE if isStore, HALT if isSYSTEM, else FETCH.
REQ-022 EXECUTE: SHALL assert rf_we iff not (isLoad|isStore|isBranch|isSYSTEM) and rdId!=0.
REQ-023 LOAD: SHALL assert mem_rstrb with mem_addr=ls_addr for one cycle, then go to WAIT_DATA.
REQ-024 WAIT_DATA: SHALL hold while mem_rbusy=1; on mem_rbusy=0 SHALL assert rf_we for one cycle (iff rdId!=0) and go to FETCH.
REQ-025 STORE: SHALL drive mem_wmask=store_wmask, mem_addr=ls_addr for one cycle, then go to WAIT_STORE; mem_wmask=0 in all other states.
REQ-026 WAIT_STORE: SHALL hold while mem_wbusy=1, go to FETCH when mem_wbusy=0.
REQ-027 HALT: SHALL remain in HALT with halted=1 and no memory requests until reset.
REQ-028 mem_addr SHALL equal pc in FETCH/WAIT_INSTR/EXECUTE/HALT and ls_addr in LOAD/WAIT_DATA/STORE/WAIT_STORE.
REQ-029 Latency with zero-wait memory SHALL be 3 cycles for ALU/branch/jump and 5 cycles for load/store.
REQ-030 pc SHALL change only in EXECUTE; wrap of 32'hFFFF_FFFC to 0 is the datapath's responsibility and SHALL be loaded unmodified.
REQ-031 mem_rbusy low in the strobe cycle itself SHALL be ignored; data is sampled only in the WAIT states.

Reset
REQ-032 On reset=1, SHALL immediately, independent of clk, set state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), rf_we=0, mem_rstrb=0, mem_wmask=0, halted=0.
REQ-033 Reset asserted in any state, including mid-transfer, SHALL abandon the transfer; first fetch SHALL occur on the first rising edge after release.

Structure
REQ-034 State encoding and RV32I opcode constants SHALL live in shared package cpu_pkg, also used by instruction_decoder.
REQ-035 SHALL contain no sub-module; decoder and datapath are instantiated by the parent.

Verification
REQ-036 Reset release, zero-wait memory, instr 32'h00500093 (addi x1,x0,5), next_pc=4 -> mem_rstrb at cycle 0 addr 0, rf_we at cycle 2, pc=4 at cycle 3.
REQ-037 Fetch with mem_rbusy high 3 cycles -> WAIT_INSTR held 3 cycles, instr latched on 4th, no extra mem_rstrb.
REQ-038 Load, ls_addr=32'h100, rdId=2, rbusy 2 cycles -> second mem_rstrb with addr 32'h100, rf_we one cycle as rbusy falls, then FETCH.
REQ-039 Store, store_wmask=4'b0011, wbusy 1 cycle -> mem_wmask=4'b0011 one cycle, FETCH after 2 cycles.
REQ-040 instr 32'h00100073 (ebreak) -> HALT, halted=1, no strobes for 20 cycles; rdId=0 ALU op -> rf_we stays 0.
REQ-041 reset pulsed during WAIT_DATA -> asynchronous return to FETCH, pc=RESET_PC, rf_we never asserted.
